// File: rtl/bit_population_counter.sv
// Multi-cycle bit population counter that counts zero or one bits of an operand, CHUNK bits per clock.
// Optional lowest-matching-index tracking is enabled by defining BITPOP_FIRST_IDX_EN.
module bit_population_counter #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(WIDTH + 1),
    localparam int IW     = $clog2(NCHUNK + 1),
    localparam int FW     = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
`ifdef BITPOP_FIRST_IDX_EN
    output logic [FW-1:0]    first_idx,
    output logic             found,
`endif
    output logic [CW-1:0]    count
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | accumulating one chunk per clock, LSB chunk first
    // DONE   | result valid for one cycle; a new start is accepted here
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] match_bits;
    logic [CW-1:0]    chunk_cnt;

    // The operand shifts right each RUN cycle, so the active chunk always sits in the low bits.
    always_comb begin
        match_bits = mode_q ? data_q[CHUNK-1:0] : ~data_q[CHUNK-1:0];
        chunk_cnt  = '0;
        for (int b = 0; b < CHUNK; b++) begin
            chunk_cnt = chunk_cnt + CW'(match_bits[b]);
        end
    end

`ifdef BITPOP_FIRST_IDX_EN
    logic [FW-1:0] lo_bit;
    logic [FW-1:0] first_val;

    always_comb begin
        lo_bit = '0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            if (match_bits[b]) lo_bit = FW'(b);
        end
        first_val = FW'(int'(idx) * CHUNK) + lo_bit;
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            data_q <= '0;
            mode_q <= 1'b0;
            idx    <= '0;
            count  <= '0;
`ifdef BITPOP_FIRST_IDX_EN
            first_idx <= '0;
            found     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_RUN;
                        data_q <= data;
                        mode_q <= mode;
                        idx    <= '0;
                        count  <= '0;
`ifdef BITPOP_FIRST_IDX_EN
                        first_idx <= '0;
                        found     <= 1'b0;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    count  <= count + chunk_cnt;
                    data_q <= data_q >> CHUNK;
                    idx    <= idx + IW'(1);
`ifdef BITPOP_FIRST_IDX_EN
                    if (!found && (|match_bits)) begin
                        found     <= 1'b1;
                        first_idx <= first_val;
                    end
`endif
                    if (idx == IW'(NCHUNK - 1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_bit_population_counter.sv
// Directed self-checking bench for bit_population_counter (WIDTH=32, CHUNK=4).
// Define BITPOP_FIRST_IDX_EN for both files to exercise first_idx/found.
module tb_bit_population_counter;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        mode;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [5:0]  count;
`ifdef BITPOP_FIRST_IDX_EN
    logic [4:0]  first_idx;
    logic        found;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit_population_counter #(.WIDTH(32), .CHUNK(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .mode     (mode),
        .data     (data),
        .busy     (busy),
        .done     (done),
`ifdef BITPOP_FIRST_IDX_EN
        .first_idx(first_idx),
        .found    (found),
`endif
        .count    (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for done, counting busy cycles; optionally pokes start/data/mode mid-run.
    task automatic wait_done(input int exp_cnt, input int inject_at, input string tag);
        int busy_cycles = 0;
        int guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (guard == inject_at) begin
                start = 1'b1;
                data  = 32'hFFFF_FFFF;
                mode  = 1'b0;
            end
            tick();
            if (guard == inject_at) start = 1'b0;
            guard++;
        end
        check(32'(done), 32'd1, {tag, " done_seen"});
        check(32'(busy_cycles), 32'd8, {tag, " busy_cycles"});
        check(32'(count), 32'(exp_cnt), {tag, " count"});
        check(32'(busy), 32'd0, {tag, " busy_at_done"});
    endtask

    task automatic do_run(input logic [31:0] d, input logic m, input int exp_cnt,
                          input int inject_at, input string tag);
        start = 1'b1;
        data  = d;
        mode  = m;
        tick();
        start = 1'b0;
        check(32'(busy), 32'd1, {tag, " busy_after_start"});
        wait_done(exp_cnt, inject_at, tag);
    endtask

    initial begin
        int seen_done;
        RST   = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        data  = '0;
        #3;
        check(32'(busy),  32'd0, "reset busy");
        check(32'(done),  32'd0, "reset done");
        check(32'(count), 32'd0, "reset count");
        @(negedge CLK);
        RST = 1'b1;

        // first edge after release takes the start
        do_run(32'h0000_0000, 1'b0, 32, -1, "zeros_m0");
        tick();
        check(32'(done),  32'd0,  "zeros_m0 done_drops");
        check(32'(count), 32'd32, "zeros_m0 count_hold");

        do_run(32'hFFFF_FFFF, 1'b0, 0, -1, "ones_m0");
        tick();
        do_run(32'hFFFF_FFFF, 1'b1, 32, -1, "ones_m1");
        tick();

        do_run(32'hF0F0_0001, 1'b1, 9, -1, "mixed_m1");
`ifdef BITPOP_FIRST_IDX_EN
        check(32'(first_idx), 32'd0, "mixed_m1 first_idx");
        check(32'(found),     32'd1, "mixed_m1 found");
`endif
        // back-to-back start in DONE
        start = 1'b1;
        data  = 32'h0000_000F;
        mode  = 1'b0;
        tick();
        start = 1'b0;
        check(32'(busy), 32'd1, "b2b busy");
        check(32'(done), 32'd0, "b2b done_drops");
        wait_done(28, -1, "b2b");
`ifdef BITPOP_FIRST_IDX_EN
        check(32'(first_idx), 32'd4, "b2b first_idx");
`endif
        tick();

        // start during RUN with different data must be ignored
        do_run(32'h1234_5678, 1'b1, 13, 2, "midrun");
        tick();
        check(32'(done),  32'd0,  "midrun single_done");
        tick();
        check(32'(busy),  32'd0,  "midrun no_restart");
        check(32'(count), 32'd13, "midrun count_hold");

        // reset in RUN cycle 4
        start = 1'b1;
        data  = 32'hFFFF_FFFF;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check(32'(count), 32'd12, "rst_run partial_count");
        #2;
        RST = 1'b0;
        #1;
        check(32'(busy),  32'd0, "rst_run busy");
        check(32'(done),  32'd0, "rst_run done");
        check(32'(count), 32'd0, "rst_run count");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check(32'(seen_done), 32'd0, "rst_run no_done_after");
        do_run(32'h0000_FFFF, 1'b1, 16, -1, "post_rst");
        tick();

`ifdef BITPOP_FIRST_IDX_EN
        do_run(32'h0000_0100, 1'b1, 1, -1, "fidx");
        check(32'(first_idx), 32'd8, "fidx first_idx");
        check(32'(found),     32'd1, "fidx found");
        tick();
        do_run(32'h0000_0000, 1'b1, 0, -1, "fidx_none");
        check(32'(found),     32'd0, "fidx_none found");
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
